// File: rtl/muntjac_fpu_int_to_float_pkg.sv
// Shared types for the integer-to-float converter: rounding modes and IEEE
// exception flags, encoded as in the RISC-V fcsr (frm / fflags).
package muntjac_fpu_int_to_float_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rounding_mode_e;

  typedef struct packed {
    logic invalid_operation;
    logic divide_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } exception_flags_t;

endpackage

// File: rtl/muntjac_fpu_int_to_float_if.sv
// Handshake bundle for the integer-to-float converter.
//   slave  : converter side (accepts operands, drives results)
//   master : client side (drives operands, consumes results)
// Signals: flush_i, in_valid_i/in_ready_o, int_i, signed_i, rounding_mode_i,
//          out_valid_o/out_ready_i, result_o, exception_o.
interface muntjac_fpu_int_to_float_if #(
  parameter int unsigned IntWidth = 64,
  parameter int unsigned ExpWidth = 11,
  parameter int unsigned SigWidth = 52
);

  logic                                             flush_i;
  logic                                             in_valid_i;
  logic                                             in_ready_o;
  logic [IntWidth-1:0]                              int_i;
  logic                                             signed_i;
  muntjac_fpu_int_to_float_pkg::rounding_mode_e     rounding_mode_i;
  logic                                             out_valid_o;
  logic                                             out_ready_i;
  logic [ExpWidth+SigWidth:0]                       result_o;
  muntjac_fpu_int_to_float_pkg::exception_flags_t   exception_o;

  modport slave (
    input  flush_i, in_valid_i, int_i, signed_i, rounding_mode_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, exception_o
  );

  modport master (
    output flush_i, in_valid_i, int_i, signed_i, rounding_mode_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, exception_o
  );

endinterface

// File: rtl/muntjac_fpu_int_to_float.sv
// Three-stage pipelined integer-to-float converter (FCVT.{S,D}.{W,WU,L,LU}).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : operand in (valid/ready), result out (valid/ready), flush
// Stage 1: sign / magnitude / leading-zero count.
// Stage 2: normalise, extract fraction, guard and sticky.
// Stage 3: round and pack; result_o / exception_o are the stage-3 registers.
module muntjac_fpu_int_to_float
  import muntjac_fpu_int_to_float_pkg::*;
#(
  parameter int unsigned IntWidth = 64,
  parameter int unsigned ExpWidth = 11,
  parameter int unsigned SigWidth = 52
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  muntjac_fpu_int_to_float_if.slave        bus
);

  localparam int unsigned LzWidth  = $clog2(IntWidth) + 1;
  localparam int unsigned ResWidth = 1 + ExpWidth + SigWidth;
  // Bits below the hidden one, padded so fraction, guard and sticky always exist.
  localparam int unsigned ExtWidth = (IntWidth - 1) + SigWidth + 2;
  localparam int unsigned Bias     = (2 ** (ExpWidth - 1)) - 1;
  localparam int unsigned ExpTop   = Bias + IntWidth - 1;

  // Handshake: each stage loads when empty or when it drains in the same cycle.
  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic in_fire, s1_fire, s2_fire;

  assign s3_ready = !s3_valid || bus.out_ready_i;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;

  assign in_fire = bus.in_valid_i && s1_ready;
  assign s1_fire = s1_valid && s2_ready;
  assign s2_fire = s2_valid && s3_ready;

  assign bus.in_ready_o  = s1_ready;
  assign bus.out_valid_o = s3_valid;

  // Valid bits; flush wins over any transfer in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= bus.in_valid_i;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) s3_valid <= s2_valid;
    end
  end

  // Stage 1: magnitude and leading-zero count (IntWidth when zero).
  logic                in_sign;
  logic [IntWidth-1:0] in_mag;
  logic [LzWidth-1:0]  in_lz;

  always_comb begin
    in_sign = bus.signed_i && bus.int_i[IntWidth-1];
    // Negating the most negative value yields 2^(IntWidth-1), the correct magnitude.
    in_mag  = in_sign ? (~bus.int_i + IntWidth'(1)) : bus.int_i;
    in_lz   = LzWidth'(IntWidth);
    for (int unsigned i = 0; i < IntWidth; i++) begin
      if (in_mag[i]) in_lz = LzWidth'(IntWidth - 1 - i);
    end
  end

  logic                s1_sign;
  logic [IntWidth-1:0] s1_mag;
  logic [LzWidth-1:0]  s1_lz;
  logic                s1_zero;
  rounding_mode_e      s1_rm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_lz   <= '0;
      s1_zero <= 1'b0;
      s1_rm   <= RNE;
    end else if (in_fire) begin
      s1_sign <= in_sign;
      s1_mag  <= in_mag;
      s1_lz   <= in_lz;
      s1_zero <= (in_mag == '0);
      s1_rm   <= bus.rounding_mode_i;
    end
  end

  // Stage 2: normalise so the hidden bit lands in the MSB, then split the rest.
  logic [IntWidth-1:0] s1_norm;
  logic [ExtWidth-1:0] s1_ext;
  logic [ExpWidth-1:0] s1_exp;
  logic [SigWidth-1:0] s1_frac;
  logic                s1_guard;
  logic                s1_sticky;
  logic                unused_hidden;

  always_comb begin
    s1_norm   = s1_mag << s1_lz;
    s1_ext    = {s1_norm[IntWidth-2:0], {(SigWidth + 2){1'b0}}};
    s1_exp    = ExpWidth'(ExpTop) - ExpWidth'(s1_lz);
    s1_frac   = s1_ext[ExtWidth-1 -: SigWidth];
    s1_guard  = s1_ext[ExtWidth-1-SigWidth];
    s1_sticky = |s1_ext[ExtWidth-2-SigWidth:0];
  end

  // The hidden bit is implied by the exponent and never stored.
  assign unused_hidden = s1_norm[IntWidth-1];

  logic                s2_sign;
  logic [ExpWidth-1:0] s2_exp;
  logic [SigWidth-1:0] s2_frac;
  logic                s2_guard;
  logic                s2_sticky;
  logic                s2_zero;
  rounding_mode_e      s2_rm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_frac   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_zero   <= 1'b0;
      s2_rm     <= RNE;
    end else if (s1_fire) begin
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp;
      s2_frac   <= s1_frac;
      s2_guard  <= s1_guard;
      s2_sticky <= s1_sticky;
      s2_zero   <= s1_zero;
      s2_rm     <= s1_rm;
    end
  end

  // Stage 3: rounding increment; a fraction carry-out bumps the exponent.
  logic                round_up;
  logic                inexact;
  logic                frac_carry;
  logic [SigWidth-1:0] frac_rnd;
  logic [ExpWidth-1:0] exp_rnd;
  logic [ResWidth-1:0] result_d;
  exception_flags_t    flags_d;

  always_comb begin
    inexact = s2_guard || s2_sticky;
    unique case (s2_rm)
      RNE:     round_up = s2_guard && (s2_sticky || s2_frac[0]);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = s2_sign && inexact;
      RUP:     round_up = !s2_sign && inexact;
      RMM:     round_up = s2_guard;
      default: round_up = 1'b0;
    endcase
    {frac_carry, frac_rnd} = {1'b0, s2_frac} + (SigWidth + 1)'(round_up);
    exp_rnd  = s2_exp + ExpWidth'(frac_carry);
    result_d = s2_zero ? '0 : {s2_sign, exp_rnd, frac_rnd};
    flags_d         = '0;
    flags_d.inexact = !s2_zero && inexact;
  end

  logic [ResWidth-1:0] result_q;
  exception_flags_t    flags_q;

  // Only loads when stage 3 can accept, so outputs hold steady under a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (s2_fire) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.exception_o = flags_q;

endmodule

// File: tb/tb_muntjac_fpu_int_to_float.sv
// Self-checking bench for muntjac_fpu_int_to_float (double, 64-bit operands).
// Reference: exact integer rounding via quotient/remainder against a
// half-ulp threshold, with a queue of expected results in acceptance order.
module tb_muntjac_fpu_int_to_float;
  import muntjac_fpu_int_to_float_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muntjac_fpu_int_to_float_if #(.IntWidth(64), .ExpWidth(11), .SigWidth(52)) bus_if ();

  muntjac_fpu_int_to_float #(.IntWidth(64), .ExpWidth(11), .SigWidth(52)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  typedef struct {
    logic [63:0] res;
    logic        nx;
    int unsigned t;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        lat_chk = 1'b0;
  logic [63:0] cur_res;
  logic        cur_nx;
  logic        s_in_ready, s_out_valid;
  logic [63:0] s_result;
  logic [4:0]  s_exc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // IEEE double of an integer, rounded with exact remainder arithmetic.
  function automatic logic [63:0] ref_conv(input logic [63:0] x, input logic sgn,
                                           input int rm, output logic nx);
    logic        neg, up;
    logic [63:0] mag, qv, rem, half;
    int          e, sh;
    neg = sgn && x[63];
    mag = neg ? 64'(64'd0 - x) : x;
    nx  = 1'b0;
    up  = 1'b0;
    if (mag == 64'd0) return 64'd0;
    e = 0;
    for (int i = 0; i < 64; i++) if ((mag >> i) != 64'd0) e = i;
    if (e <= 52) begin
      qv = mag << (52 - e);
    end else begin
      sh   = e - 52;
      qv   = mag >> sh;
      rem  = mag - (qv << sh);
      half = 64'd1 << (sh - 1);
      nx   = (rem != 64'd0);
      case (rm)
        0:       up = (rem > half) || ((rem == half) && qv[0]);
        2:       up = neg && nx;
        3:       up = !neg && nx;
        4:       up = (rem >= half);
        default: up = 1'b0;
      endcase
      qv = qv + 64'(up);
      if (qv == (64'd1 << 53)) begin
        qv = qv >> 1;
        e  = e + 1;
      end
    end
    return {neg, 11'(e + 1023), qv[51:0]};
  endfunction

  task automatic drive(input logic [63:0] x, input logic s, input int rm,
                       input logic [63:0] r, input logic n);
    bus_if.in_valid_i      = 1'b1;
    bus_if.int_i           = x;
    bus_if.signed_i        = s;
    bus_if.rounding_mode_i = rounding_mode_e'(3'(rm));
    cur_res = r;
    cur_nx  = n;
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: ;
      1: x = 64'($urandom_range(0, 1000));
      2: x = (64'd1 << $urandom_range(0, 63)) + 64'($urandom_range(0, 3));
      3: x = x >> $urandom_range(0, 63);
      default: x = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return x;
  endfunction

  task automatic drive_rand();
    logic [63:0] x, r;
    logic        s, n;
    int          rm;
    x  = rand_operand();
    s  = 1'($urandom_range(0, 1));
    rm = int'($urandom_range(0, 4));
    r  = ref_conv(x, s, rm, n);
    drive(x, s, rm, r, n);
  endtask

  // One clock: sample at the negedge, update the scoreboard, step past posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_in_ready  = bus_if.in_ready_o;
    s_out_valid = bus_if.out_valid_o;
    s_result    = bus_if.result_o;
    s_exc       = bus_if.exception_o;
    if (bus_if.flush_i) begin
      q.delete();
    end else begin
      if (s_out_valid && bus_if.out_ready_i) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 64'(s_out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check_eq("result", s_result, e.res);
          check_eq("flags", 64'(s_exc), {63'd0, e.nx});
          if (lat_chk) check_eq("latency", 64'(cyc - e.t), 64'd3);
        end
      end
      if (bus_if.in_valid_i && s_in_ready) q.push_back('{cur_res, cur_nx, cyc});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) cycle();
    if (q.size() != 0) check_eq("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic dir(input logic [63:0] x, input logic s, input int rm,
                     input logic [63:0] r, input logic n);
    drive(x, s, rm, r, n);
    check_eq("dir_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    cycle();
    bus_if.in_valid_i = 1'b0;
    drain(10);
  endtask

  task automatic fill3();
    for (int k = 0; k < 3; k++) begin
      drive_rand();
      cycle();
      check_eq("fill_accept", 64'(s_in_ready), 64'd1);
    end
    bus_if.in_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.flush_i         = 1'b0;
    bus_if.in_valid_i      = 1'b0;
    bus_if.int_i           = '0;
    bus_if.signed_i        = 1'b0;
    bus_if.rounding_mode_i = RNE;
    bus_if.out_ready_i     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus_if.out_valid_o), 64'd0);
    check_eq("rst_result", bus_if.result_o, 64'd0);
    check_eq("rst_flags", 64'(bus_if.exception_o), 64'd0);
    check_eq("rst_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4.
    lat_chk = 1'b1;
    bus_if.out_ready_i = 1'b1;
    dir(64'd1,                  1'b0, 0, 64'h3FF0_0000_0000_0000, 1'b0);
    dir(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 64'hBFF0_0000_0000_0000, 1'b0);
    dir(64'd0,                  1'b0, 0, 64'h0000_0000_0000_0000, 1'b0);
    dir(64'd0,                  1'b1, 2, 64'h0000_0000_0000_0000, 1'b0);
    dir(64'h8000_0000_0000_0000, 1'b1, 0, 64'hC3E0_0000_0000_0000, 1'b0);
    dir(64'h8000_0000_0000_0000, 1'b0, 0, 64'h43E0_0000_0000_0000, 1'b0);
    dir(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 64'h43F0_0000_0000_0000, 1'b1);
    dir(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 64'h43EF_FFFF_FFFF_FFFF, 1'b1);
    dir(64'h0020_0000_0000_0001, 1'b0, 0, 64'h4340_0000_0000_0000, 1'b1);
    dir(64'h0020_0000_0000_0001, 1'b0, 3, 64'h4340_0000_0000_0001, 1'b1);
    dir(64'hFFDF_FFFF_FFFF_FFFF, 1'b1, 2, 64'hC340_0000_0000_0001, 1'b1);
    dir(64'hFFDF_FFFF_FFFF_FFFF, 1'b1, 1, 64'hC340_0000_0000_0000, 1'b1);
    lat_chk = 1'b0;

    // Backpressure: three fill the pipe, the fourth waits.
    bus_if.out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_rand();
      cycle();
      check_eq("bp_in_ready", 64'(s_in_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("bp_hold_valid", 64'(s_out_valid), 64'd1);
      check_eq("bp_hold_ready", 64'(s_in_ready), 64'd0);
      if (q.size() != 0) check_eq("bp_hold_result", s_result, q[0].res);
    end
    bus_if.out_ready_i = 1'b1;
    cycle();
    check_eq("bp_release_ready", 64'(s_in_ready), 64'd1);
    bus_if.in_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("bp_stream_valid", 64'(s_out_valid), 64'd1);
    end
    drain(10);

    // Flush with three in flight, alongside an offered input.
    bus_if.out_ready_i = 1'b0;
    fill3();
    drive_rand();
    bus_if.flush_i = 1'b1;
    cycle();
    bus_if.flush_i    = 1'b0;
    bus_if.in_valid_i = 1'b0;
    bus_if.out_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("flush_out_valid", 64'(s_out_valid), 64'd0);
    end

    // Asynchronous reset mid-cycle with three in flight.
    bus_if.out_ready_i = 1'b0;
    fill3();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(bus_if.out_valid_o), 64'd0);
    check_eq("arst_result", bus_if.result_o, 64'd0);
    check_eq("arst_flags", 64'(bus_if.exception_o), 64'd0);
    check_eq("arst_in_ready", 64'(bus_if.in_ready_o), 64'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("arst_quiet", 64'(s_out_valid), 64'd0);
    end

    // Random traffic with random backpressure and occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else bus_if.in_valid_i = 1'b0;
      bus_if.out_ready_i = ($urandom_range(0, 3) != 0);
      bus_if.flush_i     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    bus_if.flush_i     = 1'b0;
    bus_if.in_valid_i  = 1'b0;
    bus_if.out_ready_i = 1'b1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
